writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//   Producer side of the register-file write port. Merges results from the single-cycle
//   ALU path and the multi-cycle load/mul path onto one port: write_back_en,
//   write_back_reg and write_back. Buffers slow-path results that collide with ALU
//   writes, and drops writes to $0. Flags reads of registers with a pending write so
//   decode can stall. Sits between the execute/memory stages and the register file.
// PARAMETERS
//   DEPTH  4   slow-path pending FIFO entries (power of 2, >=2)
//   DW     32  data width
//   AW     5   register index width
// PORTS
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous, active-low reset
//   alu_valid      in   1   ALU result present this cycle (no backpressure)
//   alu_reg        in   AW  ALU destination register
//   alu_data       in   DW  ALU result
//   slow_valid     in   1   slow-path result offered
//   slow_ready     out  1   slow-path accept; transfer = slow_valid & slow_ready
//   slow_reg       in   AW  slow-path destination register
//   slow_data      in   DW  slow-path result
//   a_reg, b_reg   in   AW  decode read indices (same as register-file read ports)
//   busy_a, busy_b out  1   a_reg/b_reg has an undelivered write pending
//   write_back_en  out  1   register-file write enable (registered)
//   write_back_reg out  AW  register-file write index (registered)
//   write_back     out  DW  register-file write data (registered)
// BEHAVIOUR
//   Reset (rst=0, async):
//     write_back_en=0, write_back_reg=0, write_back=0.
//     FIFO empty, all squash bits clear, slow_ready=1, busy_a=busy_b=0.
//   Output stage: one register; write_back_* updated every rising edge. ALU latency = 1 cycle.
//   Per-cycle priority, evaluated at each edge:
//     1. alu_valid=1: output <= ALU result. Any slow transfer this cycle is pushed to the FIFO.
//     2. else FIFO non-empty: pop head to output. Any slow transfer is pushed behind it.
//     3. else slow transfer: bypass straight to output (latency 1).
//     4. else write_back_en <= 0.
//   $0 rule: any selected write with reg==0 gives write_back_en=0.
//     In that case write_back_reg and write_back hold their previous values.
//   slow_ready = !full. Full = DEPTH valid entries.
//     A pop and a push in the same cycle while full are not allowed: ready is low, so no push occurs.
//   WAW squash (the ALU result is always the newer one):
//     - On an accepted ALU write to reg X!=0, every FIFO entry with reg X gets its squash bit set.
//     - A same-cycle slow transfer to X is pushed already squashed.
//     - Popping a squashed entry frees the slot and gives write_back_en=0 that cycle.
//     - The pop does not stall to find a live entry.
//   FIFO: circular, rd/wr pointers of log2(DEPTH)+1 bits. Wrap-around is exercised at every multiple of DEPTH.
//   busy_a is combinational and 1 when a_reg!=0 and a_reg matches either:
//     - a non-squashed valid FIFO entry, or
//     - the output stage while write_back_en=1.
//   busy_b is the same, using b_reg.
//   slow_valid without ready: the producer holds reg and data stable. Nothing is accepted.
//   Reset mid-operation: all queued writes are discarded. No write is issued after rst deasserts until new inputs arrive.
// TESTING
//   1. Reset with rst=0 for 2 cycles -> write_back_en=0, write_back=0, slow_ready=1, busy_a=busy_b=0.
//   2. alu_valid, reg 5, data 0x0000_00A5 for one cycle -> next cycle: write_back_en=1, reg 5, data 0xA5; then write_back_en=0.
//   3. alu_valid reg 3 and slow_valid reg 7 (0x77) in the same cycle.
//      -> cycle +1: writes reg 3; cycle +2: writes reg 7, data 0x77. busy_a=1 for a_reg=7 until the write completes.
//   4. alu_valid held 6 cycles, slow pushing regs 1..6:
//      -> slow_ready drops after 4 pushes. Then drain in order 1,2,3,4 once the ALU idles.
//      -> the next 4 pushes wrap the pointers, and order is still preserved.
//   5. Slow reg 9 queued behind an ALU write, then ALU writes reg 9 = 0x99.
//      -> reg 9 = 0x99 is written. The queued slow entry pops with write_back_en=0.
//   6. alu_valid reg 0 -> write_back_en stays 0. Then rst pulsed low with 3 entries queued -> FIFO empty and no further writes.

Source files
------------

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Producer side of the register-file write port. Each cycle it picks one of
//   three write sources, in this order: the single-cycle ALU path, the head of a
//   small pending FIFO, or a slow-path (load/mul) transfer that bypasses the
//   empty FIFO. Slow results that lose to the ALU are queued. The result is
//   registered onto one write port. Writes to register 0 are suppressed.
//   When the ALU writes a register that still has older queued slow results,
//   those entries are squashed. A squashed entry is popped without a write.
//   busy_a/busy_b tell decode that a read index has a write still in flight.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   alu_valid/alu_reg/alu_data ALU result; no backpressure
//   slow_valid/slow_ready     slow-path handshake; transfer = valid & ready
//   slow_reg/slow_data        slow-path destination and result
//   a_reg, b_reg              decode read indices
//   busy_a, busy_b            read index has an undelivered write pending
//   write_back_en/_reg/write_back  registered register-file write port
module writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_reg,
    input  logic [DW-1:0] alu_data,
    input  logic          slow_valid,
    output logic          slow_ready,
    input  logic [AW-1:0] slow_reg,
    input  logic [DW-1:0] slow_data,
    input  logic [AW-1:0] a_reg,
    input  logic [AW-1:0] b_reg,
    output logic          busy_a,
    output logic          busy_b,
    output logic          write_back_en,
    output logic [AW-1:0] write_back_reg,
    output logic [DW-1:0] write_back
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_P = (PW+1)'(DEPTH);

    // FIFO storage and pointers (one extra pointer bit separates full from empty)
    logic [AW-1:0] fifo_reg_q  [DEPTH];
    logic [AW-1:0] fifo_reg_d  [DEPTH];
    logic [DW-1:0] fifo_data_q [DEPTH];
    logic [DW-1:0] fifo_data_d [DEPTH];
    logic          fifo_sq_q   [DEPTH];
    logic          fifo_sq_d   [DEPTH];
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]   wr_ptr_q, wr_ptr_d;

    // Output stage
    logic          wb_en_q, wb_en_d;
    logic [AW-1:0] wb_reg_q, wb_reg_d;
    logic [DW-1:0] wb_data_q, wb_data_d;

    // Selection results
    logic          sel_valid_s;
    logic          sel_sq_s;
    logic [AW-1:0] sel_reg_s;
    logic [DW-1:0] sel_data_s;
    logic          push_s;
    logic          push_sq_s;

    logic [PW:0]   count_s;
    logic          full_s;
    logic          empty_s;
    logic          slow_xfer_s;
    logic [PW-1:0] rd_idx_s;
    logic [PW-1:0] wr_idx_s;
    logic          slot_live_s [DEPTH];

    assign count_s     = wr_ptr_q - rd_ptr_q;
    assign full_s      = (count_s == DEPTH_P);
    assign empty_s     = (wr_ptr_q == rd_ptr_q);
    assign slow_ready  = ~full_s;
    assign slow_xfer_s = slow_valid & ~full_s;
    assign rd_idx_s    = rd_ptr_q[PW-1:0];
    assign wr_idx_s    = wr_ptr_q[PW-1:0];

    // A slot is live when it lies within the occupied window and is not squashed
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] offset;
            offset = PW'(i) - rd_idx_s;
            if (({1'b0, offset} < count_s) && !fifo_sq_q[i]) begin
                slot_live_s[i] = 1'b1;
            end else begin
                slot_live_s[i] = 1'b0;
            end
        end
    end

    // Source selection, FIFO push/pop and WAW squash marking
    always_comb begin
        fifo_reg_d  = fifo_reg_q;
        fifo_data_d = fifo_data_q;
        fifo_sq_d   = fifo_sq_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        sel_valid_s = 1'b0;
        sel_sq_s    = 1'b0;
        sel_reg_s   = '0;
        sel_data_s  = '0;
        push_s      = 1'b0;
        push_sq_s   = 1'b0;

        if (alu_valid) begin
            sel_valid_s = 1'b1;
            sel_reg_s   = alu_reg;
            sel_data_s  = alu_data;
            push_s      = slow_xfer_s;
            // A same-cycle slow result to the same register is older than the ALU one
            push_sq_s   = (alu_reg != '0) && (slow_reg == alu_reg);
            for (int i = 0; i < DEPTH; i++) begin
                if ((alu_reg != '0) && (fifo_reg_q[i] == alu_reg)) begin
                    fifo_sq_d[i] = 1'b1;
                end else begin
                    fifo_sq_d[i] = fifo_sq_q[i];
                end
            end
        end else if (!empty_s) begin
            sel_valid_s = 1'b1;
            sel_reg_s   = fifo_reg_q[rd_idx_s];
            sel_data_s  = fifo_data_q[rd_idx_s];
            sel_sq_s    = fifo_sq_q[rd_idx_s];
            rd_ptr_d    = rd_ptr_q + 1'b1;
            push_s      = slow_xfer_s;
        end else if (slow_xfer_s) begin
            sel_valid_s = 1'b1;
            sel_reg_s   = slow_reg;
            sel_data_s  = slow_data;
        end else begin
            sel_valid_s = 1'b0;
        end

        if (push_s) begin
            fifo_reg_d[wr_idx_s]  = slow_reg;
            fifo_data_d[wr_idx_s] = slow_data;
            fifo_sq_d[wr_idx_s]   = push_sq_s;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Output stage next value; suppressed writes keep the previous index/data
    always_comb begin
        if (sel_valid_s && !sel_sq_s && (sel_reg_s != '0)) begin
            wb_en_d   = 1'b1;
            wb_reg_d  = sel_reg_s;
            wb_data_d = sel_data_s;
        end else begin
            wb_en_d   = 1'b0;
            wb_reg_d  = wb_reg_q;
            wb_data_d = wb_data_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_reg_q[i]  <= '0;
                fifo_data_q[i] <= '0;
                fifo_sq_q[i]   <= 1'b0;
            end
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            wb_en_q   <= wb_en_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_reg_q[i]  <= fifo_reg_d[i];
                fifo_data_q[i] <= fifo_data_d[i];
                fifo_sq_q[i]   <= fifo_sq_d[i];
            end
        end
    end

    // Pending-write hazard flags for the two decode read ports
    always_comb begin
        busy_a = 1'b0;
        busy_b = 1'b0;
        if (wb_en_q && (a_reg != '0) && (wb_reg_q == a_reg)) begin
            busy_a = 1'b1;
        end else begin
            busy_a = 1'b0;
        end
        if (wb_en_q && (b_reg != '0) && (wb_reg_q == b_reg)) begin
            busy_b = 1'b1;
        end else begin
            busy_b = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_live_s[i] && (a_reg != '0) && (fifo_reg_q[i] == a_reg)) begin
                busy_a = 1'b1;
            end else begin
                busy_a = busy_a;
            end
            if (slot_live_s[i] && (b_reg != '0) && (fifo_reg_q[i] == b_reg)) begin
                busy_b = 1'b1;
            end else begin
                busy_b = busy_b;
            end
        end
    end

    assign write_back_en  = wb_en_q;
    assign write_back_reg = wb_reg_q;
    assign write_back     = wb_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed scenarios followed by random
// traffic, checked against a queue-based reference model of pending writes.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic          slow_valid;
    logic          slow_ready;
    logic [AW-1:0] slow_reg;
    logic [DW-1:0] slow_data;
    logic [AW-1:0] a_reg;
    logic [AW-1:0] b_reg;
    logic          busy_a;
    logic          busy_b;
    logic          write_back_en;
    logic [AW-1:0] write_back_reg;
    logic [DW-1:0] write_back;

    writeback_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .slow_valid(slow_valid), .slow_ready(slow_ready),
        .slow_reg(slow_reg), .slow_data(slow_data),
        .a_reg(a_reg), .b_reg(b_reg), .busy_a(busy_a), .busy_b(busy_b),
        .write_back_en(write_back_en), .write_back_reg(write_back_reg),
        .write_back(write_back)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] r; logic [DW-1:0] d; logic sq; } ent_t;
    typedef struct packed { logic [AW-1:0] r; logic [DW-1:0] d; } wr_t;

    ent_t mq[$];      // model of queued slow results, oldest first
    wr_t  expq[$];    // scoreboard of writes the port must still produce
    bit            last_en;
    logic [AW-1:0] last_reg;
    bit            exp_ready, exp_busy_a, exp_busy_b;
    bit            last_acc;
    bit            mon_on;
    int            checks, errors;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit busy_of(input logic [AW-1:0] r);
        if (r == '0) return 1'b0;
        if (last_en && last_reg == r) return 1'b1;
        foreach (mq[i]) if (!mq[i].sq && mq[i].r == r) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of stimulus plus the reference-model update for the coming edge
    task automatic step(input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                        input bit sv, input logic [AW-1:0] sr, input logic [DW-1:0] sd,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        bit xfer, out_en;
        ent_t e;
        wr_t w;
        @(posedge clk); #1;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        slow_valid = sv; slow_reg = sr; slow_data = sd;
        a_reg = ra; b_reg = rb;
        exp_ready  = (mq.size() < DEPTH);
        exp_busy_a = busy_of(ra);
        exp_busy_b = busy_of(rb);
        xfer = sv && exp_ready;
        last_acc = xfer;
        out_en = 1'b0;
        w = '0;
        if (av) begin
            if (ar != '0) begin
                out_en = 1'b1; w.r = ar; w.d = ad;
                foreach (mq[i]) if (mq[i].r == ar) mq[i].sq = 1'b1;
            end
            if (xfer) begin
                e.r = sr; e.d = sd; e.sq = (ar != '0) && (sr == ar);
                mq.push_back(e);
            end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (!e.sq && e.r != '0) begin
                out_en = 1'b1; w.r = e.r; w.d = e.d;
            end
            if (xfer) begin
                e.r = sr; e.d = sd; e.sq = 1'b0;
                mq.push_back(e);
            end
        end else if (xfer && sr != '0) begin
            out_en = 1'b1; w.r = sr; w.d = sd;
        end
        if (out_en) expq.push_back(w);
        last_en = out_en;
        if (out_en) last_reg = w.r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 5'd7, 5'd9);
    endtask

    // Reset pulse: everything queued or in flight is discarded
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        alu_valid = 1'b0; slow_valid = 1'b0; alu_reg = '0; slow_reg = '0;
        alu_data = '0; slow_data = '0; a_reg = 5'd1; b_reg = 5'd2;
        mq.delete(); expq.delete();
        last_en = 1'b0; last_reg = '0;
        exp_ready = 1'b1; exp_busy_a = 1'b0; exp_busy_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_en", {31'd0, write_back_en}, 32'd0);
        chk("rst_wb_reg", {27'd0, write_back_reg}, 32'd0);
        chk("rst_wb_data", write_back, 32'd0);
        chk("rst_ready", {31'd0, slow_ready}, 32'd1);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
        rst = 1'b1;
    endtask

    // Slow producer pushes regs first.. while the ALU is busy for alu_cycles, holding when stalled
    task automatic slow_burst(input int first, input int n, input int alu_cycles);
        int k, c;
        k = 0; c = 0;
        while ((k < n || c < alu_cycles) && c < 100) begin
            step(c < alu_cycles, AW'(10 + (c % 8)), DW'(32'h100 + c),
                 k < n, AW'(first + k), DW'(32'hA000 + first + k), AW'(first), AW'(first + 1));
            if (k < n && last_acc) k++;
            c++;
        end
        idle(DEPTH + 2);
    endtask

    // Monitor: pops the scoreboard whenever the port writes and checks the hazard flags
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("slow_ready", {31'd0, slow_ready}, {31'd0, exp_ready});
                chk("busy_a", {31'd0, busy_a}, {31'd0, exp_busy_a});
                chk("busy_b", {31'd0, busy_b}, {31'd0, exp_busy_b});
                if (write_back_en) begin
                    if (expq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: got reg %0d data 0x%0h expected no write at %0t",
                                 write_back_reg, write_back, $time);
                    end else begin
                        w = expq.pop_front();
                        chk("wb_reg", {27'd0, write_back_reg}, {27'd0, w.r});
                        chk("wb_data", write_back, w.d);
                    end
                end
            end
        end
    end

    initial begin
        bit pv;
        logic [AW-1:0] pr;
        logic [DW-1:0] pd;
        checks = 0; errors = 0; mon_on = 1'b0;
        rst = 1'b0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        slow_valid = 1'b0; slow_reg = '0; slow_data = '0;
        a_reg = '0; b_reg = '0;
        last_en = 1'b0; last_reg = '0; last_acc = 1'b0;
        exp_ready = 1'b1; exp_busy_a = 1'b0; exp_busy_b = 1'b0;

        // Power-on reset, then start monitoring
        do_reset();
        mon_on = 1'b1;

        // Single ALU write
        step(1'b1, 5'd5, 32'h0000_00A5, 1'b0, '0, '0, 5'd5, 5'd0);
        idle(2);

        // ALU and slow collide: slow result queued one cycle, busy on reg 7
        step(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 5'd7, 5'd3);
        step(1'b0, '0, '0, 1'b0, '0, '0, 5'd7, 5'd3);
        step(1'b0, '0, '0, 1'b0, '0, '0, 5'd7, 5'd3);
        idle(1);

        // FIFO fill, stall, in-order drain, then wrap-around
        slow_burst(1, 6, 6);
        slow_burst(21, 4, 4);
        slow_burst(25, 5, 3);

        // WAW squash: queued reg 9 is overtaken by the ALU
        step(1'b1, 5'd20, 32'h20, 1'b1, 5'd9, 32'h09, 5'd9, 5'd20);
        step(1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 5'd9, 5'd20);
        idle(3);
        // Same-cycle squash of a slow transfer
        step(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h04, 5'd4, 5'd1);
        idle(3);

        // Writes to $0 are dropped from every source
        step(1'b1, 5'd0, 32'h55, 1'b0, '0, '0, 5'd0, 5'd1);
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h66, 5'd0, 5'd1);
        idle(2);

        // Reset with three queued entries
        step(1'b1, 5'd11, 32'h11, 1'b1, 5'd1, 32'h1, 5'd1, 5'd2);
        step(1'b1, 5'd12, 32'h12, 1'b1, 5'd2, 32'h2, 5'd1, 5'd2);
        step(1'b1, 5'd13, 32'h13, 1'b1, 5'd3, 32'h3, 5'd1, 5'd2);
        do_reset();
        idle(6);

        // Random traffic, small register range to provoke collisions
        pv = 1'b0; pr = '0; pd = '0;
        for (int i = 0; i < 2000; i++) begin
            bit av;
            logic [AW-1:0] ar;
            if (!pv) begin
                pv = ($urandom_range(0, 99) < 60);
                pr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
                pd = $urandom;
            end
            av = ($urandom_range(0, 99) < 55);
            ar = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            step(av, ar, $urandom, pv, pr, pd, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            if (pv && last_acc) pv = 1'b0;
        end
        idle(DEPTH + 4);

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d outstanding expected 0", expq.size());
        end
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
